// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave.
// Contents: HTRANS / HSIZE / HRESP encodings, the slave FSM state type, and
// helper functions for size alignment and byte-lane enables.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

  // True when the address is not a multiple of the transfer size.
  function automatic logic size_misaligned(input logic [2:0] size,
                                           input logic [1:0] addr_lo);
    case (size)
      HSIZE_HALF: return addr_lo[0];
      HSIZE_WORD: return |addr_lo;
      default:    return 1'b0;
    endcase
  endfunction

  // Byte lanes touched by a transfer; lane i carries HWDATA[8*i+7:8*i].
  function automatic logic [3:0] byte_enables(input logic [2:0] size,
                                              input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: return 4'b0001 << addr_lo;
      HSIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between one master and the SRAM slave.
// master modport drives address/control/write data and HREADY;
// slave modport drives HREADYOUT, HRESP and HRDATA.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HSIZE;
  logic [31:0] HBURST;
  logic [31:0] HTRANS;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HMASTLOCK,
           HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HMASTLOCK,
           HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM: 2^AW x 32 bits, per-byte write enables, synchronous
// write, asynchronous read.
// Ports: clk, we[3:0] byte-lane enables, addr word index, wdata, rdata.
module ahb_sram_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // NOTE: storage arrays have no reset branch; clearing them would cost a
  // write port per word and contents are only meaningful once written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Asynchronous read so a read data phase sees a write completed one edge earlier.
  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with a programmable number of data-phase wait states.
// Ports: HCLK clock, HRESET synchronous active-high reset, bus (slave modport
// of ahb_sram_slave_if) carrying all AHB address, data and response signals.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int MEM_AW      = 8,
  parameter int WAIT_STATES = 1
) (
  input logic              HCLK,
  input logic              HRESET,
  ahb_sram_slave_if.slave  bus
);

  localparam int AQW = MEM_AW + 2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t         state, state_next;
  logic [3:0]     wait_cnt, wait_cnt_next;
  logic           ok_dp, ok_dp_next;   // an OKAY transfer owns the data phase
  logic [AQW-1:0] addr_q;
  logic           write_q;
  logic [2:0]     size_q;

  logic           take;
  logic           addr_err;
  logic           is_active;
  logic [3:0]     we;
  logic [31:0]    mem_rdata;
  logic           hreadyout, hresp;
  logic [31:0]    hrdata;

  // Bus fields accepted but never decoded.
  logic unused_bits;
  assign unused_bits = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK,
                         bus.HSIZE[31:3], bus.HTRANS[31:2]};

  assign is_active = (bus.HTRANS[1:0] == HTRANS_NONSEQ) ||
                     (bus.HTRANS[1:0] == HTRANS_SEQ);

  // A new address phase is only taken while our own HREADYOUT is high,
  // i.e. when idle or in the last cycle of a data phase.
  assign take = ((state == IDLE) || (state == ERR2)) &&
                bus.HSEL && bus.HREADY && is_active;

  assign addr_err = (bus.HSIZE[2:0] > HSIZE_WORD) ||
                    size_misaligned(bus.HSIZE[2:0], bus.HADDR[1:0]) ||
                    ((bus.HADDR >> AQW) != 32'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      ok_dp    <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      ok_dp    <= ok_dp_next;
      if (take) begin
        addr_q  <= bus.HADDR[AQW-1:0];
        write_q <= bus.HWRITE;
        size_q  <= bus.HSIZE[2:0];
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    ok_dp_next    = ok_dp;
    hreadyout     = 1'b1;
    hresp         = HRESP_OKAY;

    case (state)
      IDLE, ERR2: begin
        if (state == ERR2) hresp = HRESP_ERROR;
        state_next = IDLE;
        ok_dp_next = 1'b0;
        if (take) begin
          if (addr_err) begin
            state_next = ERR1;
          end else begin
            ok_dp_next = 1'b1;
            if (WAIT_STATES > 0) begin
              state_next    = WAIT;
              wait_cnt_next = WAIT_LOAD;
            end
          end
        end
      end
      WAIT: begin
        hreadyout = 1'b0;
        if (wait_cnt == 4'd0) state_next = IDLE;
        else                  wait_cnt_next = wait_cnt - 4'd1;
      end
      ERR1: begin
        hreadyout  = 1'b0;
        hresp      = HRESP_ERROR;
        state_next = ERR2;
      end
      default: state_next = IDLE;
    endcase
  end

  // Writes commit only in the final (HREADYOUT=1) cycle; a reset in that
  // cycle drops them.
  assign we = (state == IDLE && ok_dp && write_q && !HRESET)
              ? byte_enables(size_q, addr_q[1:0]) : 4'b0000;

  assign hrdata = (ok_dp && !write_q) ? mem_rdata : 32'd0;

  ahb_sram_array #(.AW(MEM_AW)) u_array (
    .clk   (HCLK),
    .we    (we),
    .addr  (addr_q[AQW-1:2]),
    .wdata (bus.HWDATA),
    .rdata (mem_rdata)
  );

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: one instance with WAIT_STATES=1 and
// one with WAIT_STATES=0 share the clock and a common master driver.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int          MEM_AW    = 8;
  localparam logic [31:0] MEM_BYTES = 32'd1 << (MEM_AW + 2);

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_sram_slave_if bus0 ();
  ahb_sram_slave_if bus1 ();

  ahb_sram_slave #(.MEM_AW(MEM_AW), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus0));
  ahb_sram_slave #(.MEM_AW(MEM_AW), .WAIT_STATES(1)) dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus1));

  // Common master signals, steered to one slave by `which`.
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic [31:0] hwdata = 32'd0;
  logic        hready_low = 1'b0;   // another slave stalling the bus
  int          which = 1;

  assign bus0.HSEL = hsel && (which == 0);
  assign bus1.HSEL = hsel && (which == 1);
  assign bus0.HADDR = haddr;            assign bus1.HADDR = haddr;
  assign bus0.HWRITE = hwrite;          assign bus1.HWRITE = hwrite;
  assign bus0.HSIZE = {29'd0, hsize};   assign bus1.HSIZE = {29'd0, hsize};
  assign bus0.HTRANS = {30'd0, htrans}; assign bus1.HTRANS = {30'd0, htrans};
  assign bus0.HBURST = 32'd0;           assign bus1.HBURST = 32'd0;
  assign bus0.HPROT = 4'd0;             assign bus1.HPROT = 4'd0;
  assign bus0.HMASTLOCK = 1'b0;         assign bus1.HMASTLOCK = 1'b0;
  assign bus0.HWDATA = hwdata;          assign bus1.HWDATA = hwdata;
  assign bus0.HREADY = bus0.HREADYOUT && !hready_low;
  assign bus1.HREADY = bus1.HREADYOUT && !hready_low;

  logic        ro, rresp;
  logic [31:0] rdata;
  assign ro    = (which == 1) ? bus1.HREADYOUT : bus0.HREADYOUT;
  assign rresp = (which == 1) ? bus1.HRESP     : bus0.HRESP;
  assign rdata = (which == 1) ? bus1.HRDATA    : bus0.HRDATA;

  int n_cmp = 0;
  int n_err = 0;

  // Reference memory: words 0..63 of each slave (all random traffic stays there).
  logic [31:0] model [2][64];
  logic [31:0] last_rd;
  logic [31:0] b_addr [3];
  logic [31:0] b_data [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b1;
    if ((a % (32'd1 << s)) != 32'd0) return 1'b1;
    if (a >= MEM_BYTES) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_write(input int w, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] d);
    logic [31:0] b;
    int lane;
    for (int i = 0; i < (1 << s); i++) begin
      b = a + 32'(i);
      lane = int'(b[1:0]);
      model[w][b[7:2]][lane*8 +: 8] = d[lane*8 +: 8];
    end
  endtask

  // One non-pipelined transfer; checks every data-phase cycle.
  task automatic xfer(input int w, input logic [31:0] a, input logic wr,
                      input logic [2:0] s, input logic [31:0] wd);
    bit          err;
    int          n_low, exp_low;
    bit          done;
    logic [31:0] exp_rd;
    err     = is_err(a, s);
    exp_low = err ? 1 : ((w == 1) ? 1 : 0);
    exp_rd  = (!err && !wr) ? model[w][a[7:2]] : 32'd0;
    which = w;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = wr; hsize = s;
    @(posedge HCLK); #1;
    // Data phase: address bus carries non-transfers (IDLE or BUSY).
    hsel   = 1'($urandom_range(0, 1));
    htrans = ($urandom_range(0, 1) == 0) ? HTRANS_IDLE : HTRANS_BUSY;
    haddr  = $urandom;
    hwdata = wd;
    n_low = 0;
    done  = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      check("resp", 32'(rresp), 32'(err));
      check("rdata", rdata, exp_rd);
      last_rd = rdata;
      if (ro) done = 1'b1;
      else    n_low++;
      @(posedge HCLK); #1;
    end
    check("low_cycles", n_low, exp_low);
    if (!err && wr) model_write(w, a, s, wd);
  endtask

  // Back-to-back NONSEQ word transfers on the zero-wait slave.
  task automatic b2b(input logic wr);
    which = 0;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = wr; hsize = HSIZE_WORD; haddr = b_addr[0];
    @(posedge HCLK); #1;
    for (int k = 1; k <= 3; k++) begin
      check("b2b_ready", 32'(ro), 32'd1);
      check("b2b_resp", 32'(rresp), 32'd0);
      check("b2b_rdata", rdata, wr ? 32'd0 : model[0][b_addr[k-1][7:2]]);
      hwdata = b_data[k-1];
      if (k < 3) haddr = b_addr[k];
      else begin hsel = 1'b0; htrans = HTRANS_IDLE; end
      @(posedge HCLK); #1;
      if (wr) model[0][b_addr[k-1][7:2]] = b_data[k-1];
    end
    check("b2b_ready_after", 32'(ro), 32'd1);
  endtask

  initial begin
    int unsigned kind, word, lane;
    logic [2:0]  s;
    logic [31:0] a;

    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    check("rst_ready0", 32'(bus0.HREADYOUT), 32'd1);
    check("rst_resp0",  32'(bus0.HRESP),     32'd0);
    check("rst_rdata0", bus0.HRDATA,         32'd0);
    check("rst_ready1", 32'(bus1.HREADYOUT), 32'd1);
    check("rst_resp1",  32'(bus1.HRESP),     32'd0);
    check("rst_rdata1", bus1.HRDATA,         32'd0);

    // Give every modelled word a known value.
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 64; i++)
        xfer(w, 32'(i * 4), 1'b1, HSIZE_WORD, $urandom);

    // Word write then read with one wait state.
    xfer(1, 32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF);
    xfer(1, 32'h10, 1'b0, HSIZE_WORD, 32'd0);
    check("deadbeef", last_rd, 32'hDEADBEEF);

    // Byte write into lane 2 of an existing word.
    xfer(1, 32'h20, 1'b1, HSIZE_WORD, 32'h11223344);
    xfer(1, 32'h22, 1'b1, HSIZE_BYTE, 32'h00AA0000);
    xfer(1, 32'h20, 0, HSIZE_WORD, 32'd0);
    check("byte_merge", last_rd, 32'h11AA3344);

    // Unaligned and out-of-range accesses, reads and writes; word 0 must survive.
    xfer(1, 32'h401, 1'b0, HSIZE_WORD, 32'd0);
    xfer(1, 32'h400, 1'b0, HSIZE_WORD, 32'd0);
    xfer(1, 32'h401, 1'b1, HSIZE_WORD, 32'hBAD0BAD0);
    xfer(1, 32'h400, 1'b1, HSIZE_WORD, 32'hBAD1BAD1);
    xfer(1, 32'h0,   1'b0, HSIZE_WORD, 32'd0);
    xfer(0, 32'h400, 1'b1, HSIZE_WORD, 32'hBAD2BAD2);
    xfer(0, 32'h0,   1'b0, HSIZE_WORD, 32'd0);

    // Address phase while another slave holds HREADY low: ignored.
    which = 1; hready_low = 1'b1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h40; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge HCLK); #1;
    hready_low = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h12345678;
    check("stall_ready", 32'(ro), 32'd1);
    @(posedge HCLK); #1;
    check("stall_ready2", 32'(ro), 32'd1);
    xfer(1, 32'h40, 1'b0, HSIZE_WORD, 32'd0);

    // Zero wait states, pipelined writes then reads.
    b_addr[0] = 32'h0; b_addr[1] = 32'h4; b_addr[2] = 32'h8;
    b_data[0] = $urandom; b_data[1] = $urandom; b_data[2] = $urandom;
    b2b(1'b1);
    b2b(1'b0);

    // Reset during the wait cycle of a write drops it.
    which = 1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h30; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h55;
    check("rst_mid_wait", 32'(ro), 32'd0);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    check("rst_mid_ready", 32'(ro), 32'd1);
    check("rst_mid_resp", 32'(rresp), 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    xfer(1, 32'h30, 1'b0, HSIZE_WORD, 32'd0);

    // Random traffic on both slaves.
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      word = $urandom_range(0, 63);
      case (kind)
        0: begin
          s = 3'($urandom_range(3, 7));
          a = 32'(word * 4);
        end
        1: begin
          s = 3'($urandom_range(1, 2));
          a = 32'(word * 4) + ((s == HSIZE_HALF) ? 32'(1 + 2 * $urandom_range(0, 1))
                                                 : 32'($urandom_range(1, 3)));
        end
        2: begin
          s = HSIZE_WORD;
          a = ($urandom | MEM_BYTES) & ~32'h3;
        end
        default: begin
          s = 3'($urandom_range(0, 2));
          lane = $urandom_range(0, 3) & ~((32'd1 << s) - 32'd1);
          a = 32'(word * 4 + lane);
        end
      endcase
      xfer(int'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), s, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, meaning log2 of memory depth in 32-bit words (256 words = 1 KiB).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning data-phase wait cycles for OKAY transfers (range 0..15).
REQ-003 SHALL have port HCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port HRESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port HSEL, input, 1 bit: slave select.
REQ-006 SHALL have port HADDR, input, 32 bits: byte address.
REQ-007 SHALL have port HWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have ports HSIZE, HBURST and HTRANS, input, 32 bits each, matching the bus interface width; only HSIZE[2:0] and HTRANS[1:0] are decoded, and HBURST is ignored.
REQ-009 SHALL have port HPROT, input, 4 bits, and port HMASTLOCK, input, 1 bit; both accepted and ignored.
REQ-010 SHALL have port HWDATA, input, 32 bits: write data, valid in the data phase.
REQ-011 SHALL have port HREADY, input, 1 bit: bus-level ready.
REQ-012 SHALL have port HREADYOUT, output, 1 bit: slave ready.
REQ-013 SHALL have port HRESP, output, 1 bit: 0 = OKAY, 1 = ERROR.
REQ-014 SHALL have port HRDATA, output, 32 bits: read data.

Function
REQ-015 SHALL capture an address phase when HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ/SEQ), registering HADDR, HWRITE and HSIZE[2:0].
REQ-016 SHALL, for IDLE/BUSY or HSEL=0 with HREADY=1, enter no data phase and hold HREADYOUT=1, HRESP=0.
REQ-017 SHALL use FSM states IDLE, WAIT, ERR1, ERR2.
- IDLE -> WAIT: valid capture with WAIT_STATES>0.
- IDLE -> ERR1: erroneous capture.
- WAIT -> IDLE: after WAIT_STATES cycles.
- ERR1 -> ERR2 -> IDLE.
REQ-018 SHALL flag a transfer erroneous if HSIZE>2, address is unaligned to its size, or HADDR[31:MEM_AW+2] is non-zero.
REQ-019 SHALL, for an OKAY transfer, drive HREADYOUT=0, HRESP=0 for exactly WAIT_STATES data-phase cycles via a down-counter, then HREADYOUT=1 for one cycle.
REQ-020 SHALL, for an ERROR transfer, drive HREADYOUT=0/HRESP=1 (ERR1) then HREADYOUT=1/HRESP=1 (ERR2), with no memory write.
REQ-021 SHALL accept a new address phase in the final data-phase cycle (HREADY=1), so back-to-back transfers incur no idle cycle.
REQ-022 SHALL apply writes in the final data-phase cycle using byte enables derived from HSIZE/HADDR[1:0], leaving other lanes unchanged.
REQ-023 SHALL drive HRDATA with the full 32-bit word at the registered address during every read data-phase cycle; a read following a write to the same word returns the new data.
REQ-024 SHALL drive HRDATA to 0 outside read data phases and during ERR1/ERR2.
REQ-025 SHALL, when HREADY=0 from another slave while in IDLE, capture nothing.

Reset
REQ-026 SHALL, with HRESET=1 at a clock edge, go to IDLE with HREADYOUT=1, HRESP=0, HRDATA=0, and the wait counter at 0.
REQ-027 SHALL, on reset mid-transfer (WAIT/ERR1/ERR2), abandon the transfer and suppress the pending write.
REQ-028 SHALL NOT reset memory contents.

Structure
REQ-029 SHALL import shared package ahb_pkg holding: HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), HSIZE encodings (BYTE=0, HALF=1, WORD=2), HRESP constants, and the FSM state enum.
REQ-030 SHALL instantiate one sub-module, ahb_sram_array: 2^MEM_AW x 32 with 4 byte-lane write enables and an asynchronous read port.

Verification
REQ-031 SHALL verify: WAIT_STATES=1, write word 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF, exactly one HREADYOUT=0 cycle per transfer, HRESP=0.
REQ-032 SHALL verify: word write 0x11223344 to 0x20, byte write 0xAA to 0x22 (HSIZE=0) -> read of 0x20 returns 0x11AA3344.
REQ-033 SHALL verify: read at 0x401 (HSIZE=2, unaligned) and at 0x400 (out of range) -> each gives HREADYOUT 0,1 with HRESP 1,1 and memory unchanged.
REQ-034 SHALL verify: WAIT_STATES=0, back-to-back NONSEQ writes to 0x0/0x4/0x8 then reads -> HREADYOUT constantly 1 and data matches.
REQ-035 SHALL verify: HRESET asserted in the WAIT cycle of a write of 0x55 to 0x30 -> next cycle HREADYOUT=1, HRESP=0, and a later read of 0x30 returns the prior contents.
